data_mem_controller: RTL and testbench

Sequencing controller between the execute/memory stage and a variable-latency data memory. It takes the MEM_READ/MEM_WRITE strobes and FUNC3 produced by control_unit, runs a request/acknowledge transaction against the memory, and formats byte, halfword and word data in both directions. It stalls the pipeline through BUSYWAIT until each access completes.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/data_mem_controller_if.sv | 34 +++
 rtl/dmem_load_formatter.sv | 30 +++
 rtl/data_mem_controller.sv | 150 +++++++++++++++
 tb/tb_data_mem_controller.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory controller:
//   - FUNC3 access-size encodings (B, H, W, BU, HU)
//   - FSM state encoding
//   - helpers that derive the effective lane offset and detect misalignment
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Lane offset actually used for the access. Bits that would make the
    // access straddle a natural boundary are dropped: halfwords keep a[1]
    // only, words always start at lane 0. FUNC3 bit 2 plays no part in size.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return a;
            2'b01:   return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_controller_if.sv
// -----------------------------------------------------------------------------
// data_mem_controller_if
// Request/acknowledge bus between the controller (master) and the data
// memory (slave).
//   MEM_REQ      request, held until MEM_ACK
//   MEM_WE       1 = write, 0 = read
//   MEM_ADDR     word-aligned byte address
//   MEM_BYTE_EN  write lane enables (1111 for reads)
//   MEM_WDATA    lane-replicated store data
//   MEM_RDATA    read word, valid with MEM_ACK
//   MEM_ACK      one-cycle completion pulse
// -----------------------------------------------------------------------------
interface data_mem_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  MEM_REQ;
    logic                  MEM_WE;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [3:0]            MEM_BYTE_EN;
    logic [DATA_WIDTH-1:0] MEM_WDATA;
    logic [DATA_WIDTH-1:0] MEM_RDATA;
    logic                  MEM_ACK;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_BYTE_EN, MEM_WDATA,
        input  MEM_RDATA, MEM_ACK
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_BYTE_EN, MEM_WDATA,
        output MEM_RDATA, MEM_ACK
    );
endinterface

// File: rtl/dmem_load_formatter.sv
// -----------------------------------------------------------------------------
// dmem_load_formatter
// Combinational load alignment: shifts the addressed lane(s) of the memory
// word down to bit 0 and sign- or zero-extends according to FUNC3.
//   i_rdata  raw memory word
//   i_off    effective lane offset (halfwords arrive with bit 0 cleared)
//   i_func3  access encoding; 010/011/110/111 pass the word through
//   o_data   formatted load result
// -----------------------------------------------------------------------------
module dmem_load_formatter
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);
    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_off, 3'b000};
        case (i_func3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_data = {24'h0, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_data = {16'h0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/data_mem_controller.sv
// -----------------------------------------------------------------------------
// data_mem_controller
// Sequences one load/store at a time against a variable-latency data memory
// and stalls the pipeline through BUSYWAIT until the access completes.
//   CLK, RESET_N   clock, synchronous active-low reset
//   MEM_READ/WRITE load/store strobes (write wins if both set)
//   FUNC3          access size/sign encoding
//   ADDRESS        byte address
//   WRITE_DATA     store data
//   READ_DATA      registered, formatted load result
//   BUSYWAIT       combinational stall request
//   MISALIGNED     one-cycle misaligned-access flag
//   bus            memory request/ack bus (master side)
// Build option: define DMEM_MISALIGN_CHECK_EN to reject misaligned accesses
// without touching memory; otherwise offending address bits are cleared.
// -----------------------------------------------------------------------------
module data_mem_controller
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)(
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  MEM_READ,
    input  logic                  MEM_WRITE,
    input  logic [2:0]            FUNC3,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic [DATA_WIDTH-1:0] READ_DATA,
    output logic                  BUSYWAIT,
    output logic                  MISALIGNED,
    data_mem_controller_if.master bus
);
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-3:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_func3;
    logic                  r_we;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_read_data;

    logic                  w_req;
    logic                  w_mis;
    logic                  w_acc;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_req = MEM_READ | MEM_WRITE;
    assign w_acc = (r_state == ST_ACCESS);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic r_mis;
    assign w_mis      = is_misaligned(FUNC3, ADDRESS[1:0]);
    assign MISALIGNED = r_mis && (r_state == ST_DONE);
`else
    assign w_mis      = 1'b0;
    assign MISALIGNED = 1'b0;
`endif

    // ---- FSM ----
    always_ff @(posedge CLK) begin
        if (!RESET_N) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        BUSYWAIT = 1'b0;
        case (r_state)
            ST_IDLE: if (w_req) begin
                BUSYWAIT = 1'b1;
                // A rejected access skips memory but still spends one DONE
                // cycle so the pipeline sees a normal completion.
                w_next   = w_mis ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                BUSYWAIT = 1'b1;
                if (bus.MEM_ACK) w_next = ST_DONE;
            end
            // Strobes here still belong to the finished instruction.
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---- request latch and load result ----
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_func3     <= '0;
            r_we        <= 1'b0;
            r_off       <= '0;
            r_read_data <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
            r_mis       <= 1'b0;
`endif
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_addr  <= ADDRESS[ADDR_WIDTH-1:2];
                r_wdata <= WRITE_DATA;
                r_func3 <= FUNC3;
                r_we    <= MEM_WRITE;
                r_off   <= align_off(FUNC3, ADDRESS[1:0]);
`ifdef DMEM_MISALIGN_CHECK_EN
                r_mis   <= w_mis;
`endif
            end
            if (w_acc && bus.MEM_ACK && !r_we)
                r_read_data <= w_load_data;
        end
    end

    assign READ_DATA = r_read_data;

    // ---- store formatting ----
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
        if (r_we) begin
            case (r_func3[1:0])
                2'b00: begin
                    w_wdata = {4{r_wdata[7:0]}};
                    w_be    = 4'b0001 << r_off;
                end
                2'b01: begin
                    w_wdata = {2{r_wdata[15:0]}};
                    w_be    = 4'b0011 << {r_off[1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are only live while a request is outstanding.
    assign bus.MEM_REQ     = w_acc;
    assign bus.MEM_WE      = w_acc & r_we;
    assign bus.MEM_ADDR    = w_acc ? {r_addr, 2'b00} : '0;
    assign bus.MEM_BYTE_EN = w_acc ? w_be : 4'b0000;
    assign bus.MEM_WDATA   = w_acc ? w_wdata : '0;

    dmem_load_formatter u_load_fmt (
        .i_rdata (bus.MEM_RDATA),
        .i_off   (r_off),
        .i_func3 (r_func3),
        .o_data  (w_load_data)
    );
endmodule

// File: tb/tb_data_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_data_mem_controller
// Table-driven bench: each record is one complete load/store with its ACK
// delay and hand-computed bus/result expectations, run back to back. Extra
// hand-written sequences cover reset values, stray ACKs, reset mid-access
// and (with DMEM_MISALIGN_CHECK_EN) misaligned rejection.
// -----------------------------------------------------------------------------
module tb_data_mem_controller;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNC3;
    logic [31:0] ADDRESS, WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT, MISALIGNED;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_controller_if bus ();

    data_mem_controller dut (
        .CLK        (clk),
        .RESET_N    (RESET_N),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .FUNC3      (FUNC3),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSYWAIT   (BUSYWAIT),
        .MISALIGNED (MISALIGNED),
        .bus        (bus)
    );

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          k;       // ACK arrives in ACCESS cycle k
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;    // READ_DATA after the access
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic we, logic re, logic [2:0] f3,
                                logic [31:0] addr, logic [31:0] wd, logic [31:0] rd, int k,
                                logic [31:0] ea, logic [3:0] ebe, logic [31:0] ewd,
                                logic [31:0] erd);
        vec_t v;
        v.name = nm; v.we = we; v.re = re; v.f3 = f3; v.addr = addr;
        v.wdata = wd; v.rdata = rd; v.k = k; v.e_addr = ea; v.e_be = ebe;
        v.e_wdata = ewd; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    // Starts just after a rising edge with the controller in IDLE; returns
    // at the DONE-cycle sample point.
    task automatic run_vec(input vec_t v);
        MEM_WRITE  = v.we;
        MEM_READ   = v.re;
        FUNC3      = v.f3;
        ADDRESS    = v.addr;
        WRITE_DATA = v.wdata;
        @(negedge clk);
        chk(v.name, "c0_busy", 32'(BUSYWAIT), 32'd1);
        chk(v.name, "c0_req",  32'(bus.MEM_REQ), 32'd0);
        for (int c = 1; c <= v.k; c++) begin
            @(posedge clk); #1;
            if (c == v.k) begin
                bus.MEM_ACK   = 1'b1;
                bus.MEM_RDATA = v.rdata;
            end
            @(negedge clk);
            chk(v.name, "acc_req",  32'(bus.MEM_REQ), 32'd1);
            chk(v.name, "acc_busy", 32'(BUSYWAIT), 32'd1);
            if (c == 1) begin
                chk(v.name, "addr", bus.MEM_ADDR, v.e_addr);
                chk(v.name, "be",   32'(bus.MEM_BYTE_EN), 32'(v.e_be));
                chk(v.name, "we",   32'(bus.MEM_WE), 32'(v.we));
                if (v.we) chk(v.name, "wdata", bus.MEM_WDATA, v.e_wdata);
            end
        end
        @(posedge clk); #1;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 32'h0;
        @(negedge clk);
        chk(v.name, "done_busy", 32'(BUSYWAIT), 32'd0);
        chk(v.name, "done_req",  32'(bus.MEM_REQ), 32'd0);
        chk(v.name, "rdata",     READ_DATA, v.e_rd);
        chk(v.name, "done_mis",  32'(MISALIGNED), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cur_rd;

        tbl.push_back(mk("sw_104",   1, 0, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        2, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0));
        tbl.push_back(mk("lb_103",   0, 1, 3'b000, 32'h103, 32'h0,        32'h80123456, 1, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80));
        tbl.push_back(mk("lbu_103",  0, 1, 3'b100, 32'h103, 32'h0,        32'h80123456, 1, 32'h100, 4'b1111, 32'h0,        32'h00000080));
        tbl.push_back(mk("sh_102",   1, 0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        3, 32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080));
        tbl.push_back(mk("lhu_102",  0, 1, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 1, 32'h100, 4'b1111, 32'h0,        32'h00008001));
        tbl.push_back(mk("lh_100",   0, 1, 3'b001, 32'h100, 32'h0,        32'h80017FFF, 2, 32'h100, 4'b1111, 32'h0,        32'h00007FFF));
        tbl.push_back(mk("lb_101",   0, 1, 3'b000, 32'h101, 32'h0,        32'h0000C300, 1, 32'h100, 4'b1111, 32'h0,        32'hFFFFFFC3));
        tbl.push_back(mk("sb_203",   1, 0, 3'b000, 32'h203, 32'h123456A5, 32'h0,        1, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'hFFFFFFC3));
        tbl.push_back(mk("l111_108", 0, 1, 3'b111, 32'h108, 32'h0,        32'hCAFEF00D, 2, 32'h108, 4'b1111, 32'h0,        32'hCAFEF00D));
        tbl.push_back(mk("both_10c", 1, 1, 3'b010, 32'h10C, 32'h11223344, 32'hFFFFFFFF, 1, 32'h10C, 4'b1111, 32'h11223344, 32'hCAFEF00D));
`ifndef DMEM_MISALIGN_CHECK_EN
        tbl.push_back(mk("lw_101",   0, 1, 3'b010, 32'h101, 32'h0,        32'h11223344, 1, 32'h100, 4'b1111, 32'h0,        32'h11223344));
        tbl.push_back(mk("sh5_103",  1, 0, 3'b101, 32'h103, 32'h0000BEEF, 32'h0,        1, 32'h100, 4'b1100, 32'hBEEFBEEF, 32'h11223344));
`endif

        // ---- reset values ----
        RESET_N = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNC3 = 3'b000;
        ADDRESS = 32'h0; WRITE_DATA = 32'h0;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", "read_data", READ_DATA, 32'h0);
        chk("reset", "req",       32'(bus.MEM_REQ), 32'd0);
        chk("reset", "we",        32'(bus.MEM_WE), 32'd0);
        chk("reset", "addr",      bus.MEM_ADDR, 32'h0);
        chk("reset", "be",        32'(bus.MEM_BYTE_EN), 32'd0);
        chk("reset", "wdata",     bus.MEM_WDATA, 32'h0);
        chk("reset", "busy",      32'(BUSYWAIT), 32'd0);
        chk("reset", "mis",       32'(MISALIGNED), 32'd0);

        // ---- stray ACK in IDLE is ignored ----
        @(posedge clk); #1;
        RESET_N = 1'b1;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
        @(negedge clk);
        chk("idle_ack", "read_data", READ_DATA, 32'h0);
        chk("idle_ack", "req",       32'(bus.MEM_REQ), 32'd0);

        // ---- table, back to back ----
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            run_vec(tbl[i]);
            @(posedge clk); #1;
        end
        cur_rd = tbl[tbl.size()-1].e_rd;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
        @(negedge clk);
        chk("post_tbl", "busy", 32'(BUSYWAIT), 32'd0);
        chk("post_tbl", "req",  32'(bus.MEM_REQ), 32'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
        // ---- misaligned word load is rejected ----
        @(posedge clk); #1;
        MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h101;
        @(negedge clk);
        chk("mis_lw", "c0_busy", 32'(BUSYWAIT), 32'd1);
        chk("mis_lw", "c0_mis",  32'(MISALIGNED), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_lw", "done_mis",  32'(MISALIGNED), 32'd1);
        chk("mis_lw", "done_req",  32'(bus.MEM_REQ), 32'd0);
        chk("mis_lw", "done_busy", 32'(BUSYWAIT), 32'd0);
        chk("mis_lw", "rdata",     READ_DATA, cur_rd);
        @(posedge clk); #1;
        MEM_READ = 1'b0;
        @(negedge clk);
        chk("mis_lw", "after_mis", 32'(MISALIGNED), 32'd0);
        chk("mis_lw", "after_req", 32'(bus.MEM_REQ), 32'd0);
`endif

        // ---- reset during the second ACCESS cycle, then a late ACK ----
        @(posedge clk); #1;
        MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h100;
        @(negedge clk);
        chk("rst_acc", "c0_busy", 32'(BUSYWAIT), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_acc", "c1_req", 32'(bus.MEM_REQ), 32'd1);
        @(posedge clk); #1;
        RESET_N = 1'b0; MEM_READ = 1'b0;
        @(negedge clk);
        chk("rst_acc", "c2_req", 32'(bus.MEM_REQ), 32'd1);
        @(posedge clk); #1;
        RESET_N = 1'b1;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h55555555;
        @(negedge clk);
        chk("rst_acc", "req",       32'(bus.MEM_REQ), 32'd0);
        chk("rst_acc", "busy",      32'(BUSYWAIT), 32'd0);
        chk("rst_acc", "read_data", READ_DATA, 32'h0);
        @(posedge clk); #1;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
        @(negedge clk);
        chk("rst_acc", "late_ack_rd",  READ_DATA, 32'h0);
        chk("rst_acc", "late_ack_req", 32'(bus.MEM_REQ), 32'd0);

        // ---- normal operation after reset ----
        @(posedge clk); #1;
        run_vec(mk("lw_after_rst", 0, 1, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 1,
                   32'h100, 4'b1111, 32'h0, 32'h0BADF00D));
        @(posedge clk); #1;
        MEM_READ = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
